// File: rtl/awgn_frame_ctrl_if.sv
// Sample handshake and datapath strobes between the frame controller and the AWGN datapath.
// The controller takes the master modport; upstream/datapath logic takes the slave modport.
interface awgn_frame_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic dp_read;
  logic dp_reset;
  logic out_valid;
  logic out_last;

  modport master (
    input  in_valid,
    output in_ready, dp_read, dp_reset, out_valid, out_last
  );

  modport slave (
    output in_valid,
    input  in_ready, dp_read, dp_reset, out_valid, out_last
  );
endinterface

// File: rtl/awgn_frame_ctrl.sv
// AWGN frame sequencer: latches SNR into a sigma code, primes the datapath with a reset
// pulse, gates FRAME_LEN samples through valid/ready and emits latency-aligned valid/last.
module awgn_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 320000,
  parameter int unsigned CNT_W     = 19,
  parameter int unsigned PRIME_CYC = 4,
  parameter int unsigned LAT       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           snr_db,
  awgn_frame_ctrl_if.master    bus,
  output logic [7:0]           sigma,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [2:0]           state,
  output logic                 done,
  output logic                 err_snr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRIME = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int unsigned CYC_MAX = (PRIME_CYC > LAT) ? PRIME_CYC : LAT;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       sigma_q, sigma_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             err_q, err_d;
  logic             dp_reset_q, dp_reset_d;
  logic [LAT-1:0]   vld_sr_q, vld_sr_d;
  logic [LAT-1:0]   last_sr_q, last_sr_d;

  logic in_ready;
  logic accept;
  logic final_acc;
  logic snr_legal;
  logic abort_clr;
  logic [7:0] lut_sigma;

  always_comb begin
    lut_sigma = '0;
    case (snr_db)
      4'd3:    lut_sigma = 8'd128;
      4'd4:    lut_sigma = 8'd114;
      4'd5:    lut_sigma = 8'd102;
      4'd6:    lut_sigma = 8'd90;
      4'd7:    lut_sigma = 8'd81;
      4'd8:    lut_sigma = 8'd72;
      4'd9:    lut_sigma = 8'd64;
      4'd10:   lut_sigma = 8'd57;
      4'd11:   lut_sigma = 8'd51;
      4'd12:   lut_sigma = 8'd45;
      default: lut_sigma = '0;
    endcase
  end

  assign snr_legal = (snr_db >= 4'd3) && (snr_db <= 4'd12);
  assign in_ready  = (state_q == RUN);
  assign accept    = in_ready & bus.in_valid;
  assign final_acc = accept && (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign abort_clr = abort && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    sigma_d = sigma_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (snr_legal) begin
            sigma_d = lut_sigma;
            cnt_d   = '0;
            cyc_d   = '0;
            state_d = PRIME;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRIME: begin
        if (cyc_q == CYC_W'(PRIME_CYC - 1)) begin
          cyc_d   = '0;
          state_d = RUN;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (final_acc) begin
          cyc_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cyc_q == CYC_W'(LAT - 1)) begin
          cyc_d   = '0;
          state_d = DONE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the frame was doing, including a pending DONE.
    if (abort_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      cyc_d   = '0;
    end
  end

  always_comb begin
    vld_sr_d     = '0;
    last_sr_d    = '0;
    vld_sr_d[0]  = accept;
    last_sr_d[0] = final_acc;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_sr_d[i]  = vld_sr_q[i-1];
      last_sr_d[i] = last_sr_q[i-1];
    end
    if (abort_clr) begin
      vld_sr_d  = '0;
      last_sr_d = '0;
    end
  end

  // Registered from the next state so dp_reset lines up exactly with the PRIME cycles.
  assign dp_reset_d = (state_d == PRIME);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      sigma_q    <= '0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      err_q      <= 1'b0;
      dp_reset_q <= 1'b1;
      vld_sr_q   <= '0;
      last_sr_q  <= '0;
    end else begin
      state_q    <= state_d;
      sigma_q    <= sigma_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      err_q      <= err_d;
      dp_reset_q <= dp_reset_d;
      vld_sr_q   <= vld_sr_d;
      last_sr_q  <= last_sr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.dp_read   = accept;
  assign bus.dp_reset  = dp_reset_q;
  assign bus.out_valid = vld_sr_q[LAT-1];
  assign bus.out_last  = last_sr_q[LAT-1];
  assign sigma         = sigma_q;
  assign sample_cnt    = cnt_q;
  assign state         = state_q;
  assign done          = (state_q == DONE);
  assign err_snr       = err_q;

endmodule

// File: tb/tb_awgn_frame_ctrl.sv
// Bench for awgn_frame_ctrl: two instances (FRAME_LEN=8 and FRAME_LEN=1) share stimulus and are
// compared each cycle against a timestamp-based frame model, plus table and directed checks.
module tb_awgn_frame_ctrl;
  localparam int unsigned LAT   = 3;
  localparam int unsigned PRIME = 4;
  localparam int unsigned CW    = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, in_valid;
  logic [3:0] snr_db;

  awgn_frame_ctrl_if if_a ();
  awgn_frame_ctrl_if if_b ();
  assign if_a.in_valid = in_valid;
  assign if_b.in_valid = in_valid;

  logic [7:0]    sigma_a, sigma_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [2:0]    st_a, st_b;
  logic          done_a, done_b, err_a, err_b;

  awgn_frame_ctrl #(.FRAME_LEN(8), .CNT_W(CW), .PRIME_CYC(PRIME), .LAT(LAT)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .snr_db(snr_db), .bus(if_a),
    .sigma(sigma_a), .sample_cnt(cnt_a), .state(st_a), .done(done_a), .err_snr(err_a));

  awgn_frame_ctrl #(.FRAME_LEN(1), .CNT_W(CW), .PRIME_CYC(PRIME), .LAT(LAT)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .snr_db(snr_db), .bus(if_b),
    .sigma(sigma_b), .sample_cnt(cnt_b), .state(st_b), .done(done_b), .err_snr(err_b));

  typedef struct packed {
    logic [2:0]    st;
    logic          in_ready, dp_read, dp_reset, out_valid, out_last, done, err;
    logic [7:0]    sigma;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t act [2];
  assign act[0] = {st_a, if_a.in_ready, if_a.dp_read, if_a.dp_reset, if_a.out_valid,
                   if_a.out_last, done_a, err_a, sigma_a, cnt_a};
  assign act[1] = {st_b, if_b.in_ready, if_b.dp_read, if_b.dp_reset, if_b.out_valid,
                   if_b.out_last, done_b, err_b, sigma_b, cnt_b};

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model: frames described by event timestamps ----------------
  typedef struct { longint t; bit last; } ev_t;

  logic [7:0] lut_tab [0:9] = '{8'd128, 8'd114, 8'd102, 8'd90, 8'd81,
                                8'd72, 8'd64, 8'd57, 8'd51, 8'd45};
  int         frame_len [2] = '{8, 1};
  bit         active [2];
  longint     t_start [2];
  longint     t_last [2];
  int         n_acc [2];
  logic [7:0] m_sigma [2];
  bit         m_err [2];
  ev_t        evq [2][$];
  bit         m_rst   = 1'b0;
  bit         m_valid = 1'b0;
  longint     cyc     = 0;

  function automatic int exp_state(int d);
    if (!active[d])                      return 0;
    if (cyc <= t_start[d] + PRIME)       return 1;
    if (t_last[d] < 0)                   return 2;
    if (cyc <= t_last[d] + LAT)          return 3;
    return 4;
  endfunction

  task automatic model_check(int d);
    obs_t e;
    int   st;
    bit   ov;
    st = exp_state(d);
    ov = (evq[d].size() > 0) && (evq[d][0].t == cyc);
    e.st        = 3'(st);
    e.in_ready  = (st == 2);
    e.dp_read   = (st == 2) && in_valid;
    e.dp_reset  = m_rst || (st == 1);
    e.out_valid = ov;
    e.out_last  = ov && evq[d][0].last;
    e.done      = (st == 4);
    e.err       = m_err[d];
    e.sigma     = m_sigma[d];
    e.cnt       = CW'(n_acc[d]);
    n_tests++;
    if (act[d] !== e) begin
      n_fail++;
      $display("FAIL model_%s cyc=%0d actual=%h required=%h", (d == 0) ? "a" : "b", cyc, act[d], e);
    end
    if (ov) void'(evq[d].pop_front());
  endtask

  task automatic model_step(int d);
    int st;
    st = exp_state(d);
    if (!reset) begin
      active[d] = 0; n_acc[d] = 0; m_sigma[d] = '0; m_err[d] = 0; evq[d].delete();
    end else begin
      m_err[d] = 0;
      if (abort && st != 0) begin
        active[d] = 0; n_acc[d] = 0; evq[d].delete();
      end else if (st == 0) begin
        if (start && !abort) begin
          if (snr_db >= 3 && snr_db <= 12) begin
            m_sigma[d] = lut_tab[snr_db - 3];
            n_acc[d]   = 0;
            active[d]  = 1;
            t_start[d] = cyc;
            t_last[d]  = -1;
          end else begin
            m_err[d] = 1;
          end
        end
      end else if (st == 2) begin
        if (in_valid) begin
          n_acc[d]++;
          evq[d].push_back('{t: cyc + LAT, last: (n_acc[d] == frame_len[d])});
          if (n_acc[d] == frame_len[d]) t_last[d] = cyc;
        end
      end else if (st == 4) begin
        active[d] = 0;
      end
    end
  endtask

  // ---------------- activity monitor for directed checks ----------------
  int         cnt_rd_a, cnt_ov_a, cnt_last_a, cnt_done_a, cnt_dpr_a, last_ov_idx, dly_err, rd_bad;
  int         cnt_rd_b, cnt_done_b;
  longint     a_last_rd, a_done, b_acc, b_done;
  logic [7:0] rd_hist = '0;

  task automatic clr_mon();
    cnt_rd_a = 0; cnt_ov_a = 0; cnt_last_a = 0; cnt_done_a = 0; cnt_dpr_a = 0;
    last_ov_idx = 0; dly_err = 0; rd_bad = 0; cnt_rd_b = 0; cnt_done_b = 0;
    a_last_rd = 0; a_done = 0; b_acc = 0; b_done = 0;
  endtask

  task automatic monitor();
    if (if_a.dp_read === 1'b1) begin
      cnt_rd_a++; a_last_rd = cyc;
      if (in_valid !== 1'b1) rd_bad++;
    end
    if (if_a.out_valid === 1'b1) begin
      cnt_ov_a++;
      if (if_a.out_last === 1'b1) last_ov_idx = cnt_ov_a;
    end
    if (if_a.out_last === 1'b1) cnt_last_a++;
    if (done_a === 1'b1) begin cnt_done_a++; a_done = cyc; end
    if (if_a.dp_reset === 1'b1) cnt_dpr_a++;
    if (if_a.out_valid !== rd_hist[LAT-1]) dly_err++;
    rd_hist = {rd_hist[6:0], (if_a.dp_read === 1'b1)};
    if (if_b.dp_read === 1'b1) begin cnt_rd_b++; b_acc = cyc; end
    if (done_b === 1'b1) begin cnt_done_b++; b_done = cyc; end
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_valid) for (int d = 0; d < 2; d++) model_check(d);
    monitor();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    m_rst = !reset;
    if (!reset) m_valid = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, a, e);
    end
  endtask

  task automatic wait_a_done(int budget);
    for (int k = 0; k < budget && cnt_done_a == 0; k++) tick();
    chk("a_done_within_budget", (cnt_done_a > 0), 1);
  endtask

  task automatic start_frame(logic [3:0] snr);
    snr_db = snr; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- SNR table vectors ----------------
  typedef struct { logic [3:0] snr; bit legal; logic [7:0] sig; } vec_t;
  vec_t vt [14];
  logic [7:0] exp_sig;

  initial begin
    vt = '{'{4'd2, 0, 8'd0}, '{4'd13, 0, 8'd0}, '{4'd12, 1, 8'd45}, '{4'd3, 1, 8'd128},
           '{4'd4, 1, 8'd114}, '{4'd0, 0, 8'd0}, '{4'd5, 1, 8'd102}, '{4'd6, 1, 8'd90},
           '{4'd7, 1, 8'd81}, '{4'd15, 0, 8'd0}, '{4'd8, 1, 8'd72}, '{4'd9, 1, 8'd64},
           '{4'd10, 1, 8'd57}, '{4'd11, 1, 8'd51}};

    reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; snr_db = '0;
    clr_mon();

    // Reset held three cycles, start/abort asserted to show reset dominates
    start = 1'b1; abort = 1'b1; snr_db = 4'd8;
    repeat (3) tick();
    chk("rst_state", st_a, 0);
    chk("rst_dp_reset", if_a.dp_reset, 1);
    chk("rst_sigma", sigma_a, 0);
    chk("rst_in_ready", if_a.in_ready, 0);
    chk("rst_out_valid", if_a.out_valid, 0);
    start = 1'b0; abort = 1'b0; reset = 1'b1;
    tick();
    chk("rst_release_dp_reset", if_a.dp_reset, 0);

    // Abort and start together in IDLE: no transition
    snr_db = 4'd6; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_state", st_a, 0);
    chk("abort_start_idle_sigma", sigma_a, 0);

    // SNR LUT and illegal-SNR handling
    exp_sig = '0;
    for (int i = 0; i < 14; i++) begin
      start_frame(vt[i].snr);
      if (vt[i].legal) exp_sig = vt[i].sig;
      chk($sformatf("lut_err_snr%0d", vt[i].snr), err_a, !vt[i].legal);
      chk($sformatf("lut_state_snr%0d", vt[i].snr), st_a, vt[i].legal ? 1 : 0);
      chk($sformatf("lut_sigma_snr%0d", vt[i].snr), sigma_a, exp_sig);
      abort = vt[i].legal;
      tick();
      abort = 1'b0;
      chk($sformatf("lut_err_clear_snr%0d", vt[i].snr), err_a, 0);
      chk($sformatf("lut_back_idle_snr%0d", vt[i].snr), st_a, 0);
    end

    // Full frame, in_valid held high
    clr_mon();
    start_frame(4'd8);
    chk("frame_sigma", sigma_a, 72);
    in_valid = 1'b1;
    wait_a_done(60);
    in_valid = 1'b0;
    chk("frame_dp_reset_cycles", cnt_dpr_a, PRIME);
    chk("frame_reads", cnt_rd_a, 8);
    chk("frame_out_valids", cnt_ov_a, 8);
    chk("frame_last_on_8th_valid", last_ov_idx, 8);
    chk("frame_last_count", cnt_last_a, 1);
    chk("frame_done_latency", a_done - a_last_rd, LAT + 1);
    chk("frame_sample_cnt", cnt_a, 8);
    tick();
    chk("frame_done_single", cnt_done_a, 1);
    chk("frame_state_idle", st_a, 0);

    // Frame with in_valid toggling
    clr_mon();
    start_frame(4'd4);
    for (int k = 0; k < 100 && cnt_done_a == 0; k++) begin
      in_valid = ~in_valid;
      tick();
    end
    chk("toggle_done_seen", cnt_done_a, 1);
    in_valid = 1'b0;
    chk("toggle_reads", cnt_rd_a, 8);
    chk("toggle_read_gated", rd_bad, 0);
    chk("toggle_out_valids", cnt_ov_a, 8);
    chk("toggle_delay_lat", dly_err, 0);
    chk("toggle_sigma", sigma_a, 114);

    // Abort after 5 of 8 accepts
    clr_mon();
    start_frame(4'd8);
    in_valid = 1'b1;
    for (int k = 0; k < 40 && cnt_rd_a < 5; k++) tick();
    chk("abort_five_reads", cnt_rd_a, 5);
    in_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", st_a, 0);
    chk("abort_sample_cnt", cnt_a, 0);
    chk("abort_dp_reset", if_a.dp_reset, 0);
    cnt_ov_a = 0;
    repeat (10) tick();
    chk("abort_no_out_valid", cnt_ov_a, 0);
    chk("abort_no_last", cnt_last_a, 0);
    chk("abort_no_done", cnt_done_a, 0);
    clr_mon();
    start_frame(4'd10);
    chk("post_abort_sigma", sigma_a, 57);
    in_valid = 1'b1;
    wait_a_done(60);
    in_valid = 1'b0;
    chk("post_abort_reads", cnt_rd_a, 8);
    chk("post_abort_cnt", cnt_a, 8);

    // FRAME_LEN=1 instance with a start pulsed during RUN
    repeat (2) tick();
    clr_mon();
    start_frame(4'd5);
    for (int k = 0; k < 20 && st_b !== 3'd2; k++) tick();
    chk("len1_reached_run", st_b, 2);
    snr_db = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len1_start_ignored_state", st_b, 2);
    chk("len1_start_ignored_sigma", sigma_b, 102);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && cnt_done_b == 0; k++) tick();
    repeat (6) tick();
    in_valid = 1'b0;
    chk("len1_single_accept", cnt_rd_b, 1);
    chk("len1_single_done", cnt_done_b, 1);
    chk("len1_done_latency", b_done - b_acc, LAT + 1);
    chk("len1_sample_cnt", cnt_b, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 2500; k++) begin
      reset    = ($urandom_range(0, 299) != 0);
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      snr_db   = 4'($urandom_range(0, 15));
      in_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    tick();
    chk("final_reset_state", st_a, 0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/awgn_frame_ctrl.md
Name: awgn_frame_ctrl

Overview:
Frame sequencer for the AWGN channel datapath. It latches a per-frame SNR setting and drives the matching sigma code. It also pulses the datapath's active-high reset so every frame starts from the same LFSR seeds and an empty FIR. Input samples are gated into the datapath through a valid/ready handshake, and a delayed valid/last strobe is produced that is aligned with the noisy output samples.

Parameters:
FRAME_LEN, 320000, samples per frame (must be >= 1)
CNT_W, 19, sample counter width (2^CNT_W > FRAME_LEN)
PRIME_CYC, 4, cycles dp_reset is held high before sampling (must be >= 1)
LAT, 3, datapath latency from dp_read to valid output sample (must be >= 1)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  frame request; sampled only in IDLE
abort  in  1  cancel current frame
snr_db  in  4  requested SNR in dB; legal range 3..12
in_valid  in  1  upstream sample available
in_ready  out  1  controller accepts a sample this cycle
dp_read  out  1  datapath read strobe (= in_valid & in_ready)
dp_reset  out  1  active-high datapath reset
sigma  out  8  noise scale code for latched SNR
out_valid  out  1  datapath output sample valid
out_last  out  1  final sample of frame on output
sample_cnt  out  CNT_W  samples accepted in current frame
state  out  3  FSM state code
done  out  1  one-cycle frame-complete pulse
err_snr  out  1  one-cycle illegal-SNR pulse

Behaviour:
- Reset (reset=0 at edge): state=IDLE. dp_reset=1; all other outputs 0, including sigma and sample_cnt. Delay line is cleared. Reset dominates abort and start.
- State codes: IDLE=0, PRIME=1, RUN=2, DRAIN=3, DONE=4.
- Sigma LUT:
  - 3->128, 4->114, 5->102, 6->90, 7->81
  - 8->72, 9->64, 10->57, 11->51, 12->45
- IDLE: in_ready=0, dp_reset=0.
  - start=1 with legal snr_db: load sigma from the LUT, clear sample_cnt, go to PRIME.
  - start=1 with snr_db outside 3..12: err_snr=1 for the next cycle, sigma unchanged, stay in IDLE.
- PRIME: dp_reset=1 for exactly PRIME_CYC cycles, then RUN. in_ready=0 throughout.
- RUN: in_ready=1 combinationally while in RUN. dp_read=in_valid&in_ready.
  - Each accept increments sample_cnt.
  - The accept that makes sample_cnt==FRAME_LEN moves to DRAIN, so in_ready=0 from the next cycle.
  - Gaps on in_valid stall counting; there is no timeout.
- DRAIN: lasts LAT cycles, then DONE.
- DONE: done=1 for one cycle, then IDLE. sample_cnt and sigma hold until the next start.
- Output alignment:
  - out_valid is dp_read delayed through a LAT-stage shift register.
  - out_last is (accept of final sample) delayed the same way.
  - Last accept at cycle t gives out_valid=out_last=1 at t+LAT; done=1 at t+LAT+1.
- start outside IDLE is ignored; snr_db changes outside IDLE do not affect sigma.
- abort=1 in any state except IDLE: next state IDLE.
  - Delay line is cleared, so no further out_valid.
  - sample_cnt is cleared; no done pulse.
  - dp_reset=0 unless reset is also asserted.
- abort and start together in IDLE: abort wins, no transition.
- FRAME_LEN=1: first accept goes directly RUN->DRAIN.

Test Plan:
- Reset held 3 cycles -> state=0, dp_reset=1, sigma=0, in_ready=0, out_valid=0; after release dp_reset=0.
- start with snr_db=8, FRAME_LEN=8, PRIME_CYC=4, LAT=3, in_valid tied high:
  - sigma=72 and dp_reset=1 for 4 cycles.
  - 8 consecutive dp_read pulses; out_last coincides with the 8th out_valid.
  - done one cycle later; sample_cnt=8.
- Same frame with in_valid toggling 1,0,1,0 -> dp_read only on in_valid=1, 8 accepts total, out_valid pattern matches dp_read delayed by exactly 3 cycles.
- start with snr_db=2, then snr_db=13 -> err_snr pulses each time, state stays 0, sigma keeps its prior value. snr_db=12 and snr_db=3 give sigma=45 and sigma=128.
- abort after 5 of 8 accepts -> IDLE next cycle, sample_cnt=0, no out_last, no done. A following start at snr_db=10 runs cleanly with sigma=57.
- FRAME_LEN=1, plus start pulsed during RUN -> single accept, done at accept+LAT+1, the mid-frame start is ignored, exactly one done.
